keccak_rho_unit: RTL and testbench
==================================

Name: keccak_rho_unit

Overview:
- Parametrised Keccak rho (lane-rotate) engine over a slice-oriented state: LANE_W words of 25 bits, word z = slice z, bit x+5y = lane (x,y).
- Loads a full state through a valid/ready input stream, then rotates all 24 non-zero lanes in place.
- Supports forward rho or inverse rho, then drains the state through a valid/ready output stream.
- Sits between the theta and pi stages of the permutation datapath and replaces the fixed 64-bit rotate datapath with its external controller.

Parameters:
- LANE_W, 64, lane width = slice count; power of two, 8..64.
- ADDR_W, $clog2(LANE_W), slice address width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- mode  input  1  sampled at accepted start; 0 = rho, 1 = inverse rho.
- in_valid  input  1  input slice valid.
- in_ready  output  1  unit accepts a slice this cycle.
- in_slice  input  25  input slice, bit x+5y = lane (x,y).
- out_valid  output  1  output slice valid.
- out_ready  input  1  downstream accepts.
- out_slice  output  25  output slice; 0 when out_valid is 0.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the cycle the last slice is accepted downstream.

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, out_valid, busy, done = 0; slice RAM, lane register and all counters cleared to 0; latched mode = 0.
- IDLE -> LOAD on start=1. Latch mode. In any other state start is ignored.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes in_slice to slice address z, in order z = 0..LANE_W-1. The first slice accepted is slice 0.
  - After slice LANE_W-1: t=0 and the state goes to EXTRACT.
- Lane schedule (package tables, indexed by t = 0..23):
  - Lane bit b(t) = x+5y. Start at (x,y)=(1,0); next (x,y) = (y, (2x+3y) mod 5).
  - Offset r(t) = ((t+1)(t+2)/2 mod 64) mod LANE_W, i.e. the low ADDR_W bits of the 64-bit table. r(t) lists 1,3,6,10,15,21,28,36,45,55,2,14,27,41,56,8,25,43,62,18,39,61,20,44.
  - Lane 0 is never touched.
- EXTRACT: for z = 0..LANE_W-1, one per cycle, lane_reg[z] <= ram[z][b(t)] (combinational RAM read). Takes LANE_W cycles, then WRITEBACK.
- WRITEBACK: for z = 0..LANE_W-1, one per cycle, ram[z] <= ram[z] with bit b(t) replaced by a bit of lane_reg:
  - rho: lane_reg[(z - r) mod LANE_W]
  - inverse rho: lane_reg[(z + r) mod LANE_W]
  - All other 24 bits are preserved.
  - After z = LANE_W-1: if t=23 go to DRAIN with z=0; else t++ and go to EXTRACT.
  - If r(t)=0 (possible when LANE_W<64), the write-back still executes and the lane is unchanged.
- DRAIN:
  - out_valid=1, out_slice = ram[z].
  - z advances only on out_valid&out_ready. out_slice is held stable while stalled.
  - On acceptance of z = LANE_W-1: done=1 for that cycle only, and the state goes to IDLE the next cycle.
- Latency:
  - LOAD: LANE_W accepted beats.
  - Compute: exactly 48*LANE_W cycles from the cycle after the last accepted input to the first out_valid=1 (3072 cycles at LANE_W=64).
  - DRAIN: LANE_W beats.
- Reset mid-operation: immediate return to reset values. Partial state is discarded. No done pulse.
- Address counters wrap modulo LANE_W. Arithmetic (z ± r) uses ADDR_W-bit unsigned wrap.

Decomposition:
- Package keccak_rho_pkg:
  - state enum (IDLE, LOAD, EXTRACT, WRITEBACK, DRAIN).
  - 24-entry lane-bit table, 5 bits per entry.
  - 24-entry 6-bit offset table.
  - Function masking an offset to ADDR_W bits.
- Sub-module rho_slice_ram, parametrised by DEPTH and WIDTH=25:
  - async reset clear, synchronous write, combinational read.
  - one write port, one read port.
- FSM, counters (t 0..23, z 0..LANE_W-1) and lane register stay in keccak_rho_unit.

Test Plan:
- LANE_W=64, rho; lane 1 = bit 0 of slice 0 only, all else 0 -> output slice 1 has bit 1 set; all other bits 0; done pulses once.
- LANE_W=64, random state -> output equals a software rho model bit-exactly. Lane 0 (bit 0 of every slice) unchanged. First out_valid exactly 3072 cycles after the last accepted input.
- LANE_W=8, rho; lane 10 (bit 10) = 1 at z=0 and lane 3 = 1 at z=0 -> lane 10 set at z=3 (r=3); lane 3 set at z=4 (28 mod 8).
- Round trip: rho of random state, then inverse rho of the result (LANE_W=16) -> original state; mode changes on start while busy are ignored.
- Backpressure: out_ready toggled pseudo-randomly, in_valid gaps in LOAD -> no slice lost or duplicated; out_slice stable while stalled.
- rst asserted during WRITEBACK at t=5 -> outputs at reset values immediately; a fresh start/load of all-ones -> output all ones.

Source files
------------

// File: rtl/keccak_rho_pkg.sv
// keccak_rho_pkg: shared types and constant tables for the Keccak rho engine.
//   state_e     : controller states
//   LANE_BIT    : bit position x+5y (within a 25-bit slice) of the t-th rotated lane
//   RHO_OFFSET  : 64-bit-lane rotation offset of the t-th rotated lane
//   mask_offset : reduces a 64-bit offset to the configured lane width
package keccak_rho_pkg;

  localparam int SLICE_W   = 25;
  localparam int NUM_STEPS = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXTRACT,
    WRITEBACK,
    DRAIN
  } state_e;

  // Walk (x,y) from (1,0) with (x,y) <- (y, 2x+3y mod 5); entry is x+5y.
  localparam logic [4:0] LANE_BIT [NUM_STEPS] = '{
    5'd1,  5'd10, 5'd7,  5'd11, 5'd17, 5'd18, 5'd3,  5'd5,
    5'd16, 5'd8,  5'd21, 5'd24, 5'd4,  5'd15, 5'd23, 5'd19,
    5'd13, 5'd12, 5'd2,  5'd20, 5'd14, 5'd22, 5'd9,  5'd6
  };

  // Triangular numbers (t+1)(t+2)/2 mod 64.
  localparam logic [5:0] RHO_OFFSET [NUM_STEPS] = '{
    6'd1,  6'd3,  6'd6,  6'd10, 6'd15, 6'd21, 6'd28, 6'd36,
    6'd45, 6'd55, 6'd2,  6'd14, 6'd27, 6'd41, 6'd56, 6'd8,
    6'd25, 6'd43, 6'd62, 6'd18, 6'd39, 6'd61, 6'd20, 6'd44
  };

  // Lane width is a power of two, so "mod LANE_W" is a low-bit mask.
  function automatic logic [5:0] mask_offset(input logic [5:0] off, input int addr_w);
    return off & 6'((1 << addr_w) - 1);
  endfunction

endpackage

// File: rtl/keccak_rho_unit_ram.sv
// rho_slice_ram: slice storage for the rho engine.
//   clk, rst (async, active-low clear of every word)
//   we / wr_addr / wr_data : synchronous write port
//   rd_addr / rd_data      : combinational read port
module rho_slice_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 25,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/keccak_rho_unit.sv
// keccak_rho_unit: slice-serial Keccak rho / inverse-rho engine.
//   start/mode          : begin an operation (mode 0 = rho, 1 = inverse rho)
//   in_valid/in_ready/in_slice    : LANE_W slices loaded in order z = 0..LANE_W-1
//   out_valid/out_ready/out_slice : LANE_W slices drained in order, 0 when idle
//   busy : not IDLE;  done : pulse on acceptance of the last output slice
// Each of the 24 non-zero lanes is copied into lane_q (EXTRACT) and written
// back rotated into the same bit column (WRITEBACK).
module keccak_rho_unit
  import keccak_rho_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int ADDR_W = $clog2(LANE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [4:0]          t_q, t_d;
  logic [ADDR_W-1:0]   z_q, z_d;
  logic [LANE_W-1:0]   lane_q, lane_d;

  logic                ram_we;
  logic [SLICE_W-1:0]  ram_wr_data;
  logic [SLICE_W-1:0]  ram_rd_data;

  logic [4:0]          cur_bit;
  logic [ADDR_W-1:0]   cur_off;
  logic [ADDR_W-1:0]   src_z;
  logic                z_last;

  assign cur_bit = LANE_BIT[t_q];
  assign cur_off = ADDR_W'(mask_offset(RHO_OFFSET[t_q], ADDR_W));
  // Rho moves lane bit z-r to z; inverse rho pulls from z+r. Both wrap at ADDR_W bits.
  assign src_z   = mode_q ? (z_q + cur_off) : (z_q - cur_off);
  assign z_last  = (z_q == ADDR_W'(LANE_W - 1));

  rho_slice_ram #(
    .DEPTH (LANE_W),
    .WIDTH (SLICE_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (z_q),
    .wr_data (ram_wr_data),
    .rd_addr (z_q),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    t_d         = t_q;
    z_d         = z_q;
    lane_d      = lane_q;
    ram_we      = 1'b0;
    ram_wr_data = in_slice;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = mode;
          z_d     = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          ram_we = 1'b1;
          z_d    = z_q + 1'b1;
          if (z_last) begin
            state_d = EXTRACT;
            t_d     = '0;
          end
        end
      end
      EXTRACT: begin
        lane_d[z_q] = ram_rd_data[cur_bit];
        z_d         = z_q + 1'b1;
        if (z_last) begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        ram_we               = 1'b1;
        ram_wr_data          = ram_rd_data;
        ram_wr_data[cur_bit] = lane_q[src_z];
        z_d                  = z_q + 1'b1;
        if (z_last) begin
          if (t_q == 5'(NUM_STEPS - 1)) begin
            state_d = DRAIN;
          end else begin
            t_d     = t_q + 1'b1;
            state_d = EXTRACT;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          z_d = z_q + 1'b1;
          if (z_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      t_q     <= '0;
      z_q     <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      t_q     <= t_d;
      z_q     <= z_d;
      lane_q  <= lane_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_slice = out_valid ? ram_rd_data : '0;
  assign busy      = (state_q != IDLE);
  assign done      = out_valid && out_ready && z_last;

endmodule

// File: tb/tb_keccak_rho_unit.sv
module tb_keccak_rho_unit;

  localparam int NI = 3;  // instance 0: LANE_W=64, 1: LANE_W=8, 2: LANE_W=16

  // Reference rotation offsets indexed [x][y].
  localparam int ROT [5][5] = '{
    '{0, 36, 3, 41, 18},
    '{1, 44, 10, 45, 2},
    '{62, 6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39, 8, 14}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start     [NI];
  logic        mode      [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [24:0] in_slice  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [24:0] out_slice [NI];
  logic        busy      [NI];
  logic        done      [NI];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit stall_en = 1'b0;

  logic [24:0] exp_q[$];
  logic [24:0] src  [64];
  logic [24:0] expv [64];
  logic [24:0] orig [64];
  logic [24:0] obs  [64];

  always #5 clk = ~clk;

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LW = (gi == 0) ? 64 : ((gi == 1) ? 8 : 16);

    keccak_rho_unit #(.LANE_W(LW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[gi]),
      .mode      (mode[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_slice  (in_slice[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_slice (out_slice[gi]),
      .busy      (busy[gi]),
      .done      (done[gi])
    );

    // Monitor: pops the scoreboard on every accepted output beat.
    int          beat = 0;
    bit          stalled = 1'b0;
    logic [24:0] held;
    always @(negedge clk) begin
      if (!rst) begin
        beat    = 0;
        stalled = 1'b0;
      end else begin
        if (stalled)
          check_eq($sformatf("stall_hold i%0d z%0d", gi, beat), 64'(out_slice[gi]), 64'(held));
        if (out_valid[gi] && out_ready[gi]) begin
          if (exp_q.size() == 0) begin
            check_eq($sformatf("unexpected_beat i%0d", gi), 64'(out_slice[gi]), 64'h1_0000_0000);
          end else begin
            check_eq($sformatf("slice i%0d z%0d", gi, beat), 64'(out_slice[gi]), 64'(exp_q.pop_front()));
          end
          obs[beat] = out_slice[gi];
          check_eq($sformatf("done_flag i%0d z%0d", gi, beat), 64'(done[gi]), 64'(beat == LW - 1));
          if (done[gi]) done_cnt++;
          beat = (beat == LW - 1) ? 0 : beat + 1;
        end else if (done[gi] || (!out_valid[gi] && out_slice[gi] != 25'd0)) begin
          check_eq($sformatf("idle_outputs i%0d", gi), {31'd0, done[gi], 7'd0, out_slice[gi]}, 64'd0);
        end
        stalled = out_valid[gi] && !out_ready[gi];
        held    = out_slice[gi];
      end
    end
  end

  // Downstream readiness, optionally pseudo-random.
  initial begin
    for (int i = 0; i < NI; i++) out_ready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) out_ready[i] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int w, input bit inv);
    for (int z = 0; z < w; z++) begin
      for (int b = 0; b < 25; b++) begin
        int r, zz;
        r  = ROT[b % 5][b / 5] % w;
        zz = inv ? (z + r) % w : (z - r + w) % w;
        expv[z][b] = src[zz][b];
      end
    end
  endtask

  task automatic push_exp(input int w);
    for (int z = 0; z < w; z++) exp_q.push_back(expv[z]);
  endtask

  task automatic do_start(input int sel, input bit m);
    start[sel] = 1'b1;
    mode[sel]  = m;
    tick();
    start[sel] = 1'b0;
    mode[sel]  = ~m;
  endtask

  task automatic load(input int sel, input int w, input bit gaps, input bit poke);
    for (int z = 0; z < w; z++) begin
      int  n = 0;
      bit  acc;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid[sel] = 1'b0;
        tick();
      end
      start[sel]    = poke && (z == w / 2);
      in_valid[sel] = 1'b1;
      in_slice[sel] = src[z];
      do begin
        @(negedge clk);
        acc = in_ready[sel];
        tick();
        n++;
      end while (!acc && n < 50);
      if (!acc) check_eq("load_timeout", 64'(z), 64'hFFFF);
    end
    start[sel]    = 1'b0;
    in_valid[sel] = 1'b0;
    in_slice[sel] = '0;
  endtask

  task automatic wait_first_out(input int sel, input int w);
    int cnt = 0;
    while (cnt <= 48 * w + 16) begin
      @(negedge clk);
      if (out_valid[sel]) break;
      cnt++;
    end
    check_eq($sformatf("latency i%0d", sel), 64'(cnt), 64'(48 * w));
    tick();
  endtask

  task automatic run(input int sel, input int w, input bit m, input bit gaps, input bit poke);
    int d0 = done_cnt;
    int n  = 0;
    do_start(sel, m);
    load(sel, w, gaps, poke);
    wait_first_out(sel, w);
    while (done_cnt == d0 && n < 40 * w) begin
      @(negedge clk);
      n++;
    end
    repeat (3) tick();
    check_eq($sformatf("done_count i%0d", sel), 64'(done_cnt - d0), 64'd1);
    check_eq($sformatf("queue_empty i%0d", sel), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] l0_got, l0_exp;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; mode[i] = 1'b0; in_valid[i] = 1'b0; in_slice[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("reset_state i%0d", i),
               {32'd0, in_ready[i], out_valid[i], busy[i], done[i], 3'd0, out_slice[i]}, 64'd0);
    rst = 1'b1;
    tick();

    // Single lane-1 bit at z=0 moves to z=1 (offset 1).
    for (int z = 0; z < 64; z++) begin src[z] = '0; expv[z] = '0; end
    src[0]  = 25'h1 << 1;
    expv[1] = 25'h1 << 1;
    push_exp(64);
    run(0, 64, 1'b0, 1'b0, 1'b0);

    // Random full state, LANE_W=64.
    for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
    model(64, 1'b0);
    push_exp(64);
    run(0, 64, 1'b0, 1'b0, 1'b0);
    for (int z = 0; z < 64; z++) begin
      l0_got[z] = obs[z][0];
      l0_exp[z] = src[z][0];
    end
    check_eq("lane0_untouched", l0_got, l0_exp);

    // LANE_W=8: lane 10 shifts by 3, lane 3 shifts by 28 mod 8 = 4.
    for (int z = 0; z < 8; z++) begin src[z] = '0; expv[z] = '0; end
    src[0]  = (25'h1 << 10) | (25'h1 << 3);
    expv[3] = 25'h1 << 10;
    expv[4] = 25'h1 << 3;
    push_exp(8);
    run(1, 8, 1'b0, 1'b0, 1'b0);

    // LANE_W=16 round trip with backpressure, input gaps and ignored starts.
    stall_en = 1'b1;
    for (int z = 0; z < 16; z++) begin src[z] = 25'($urandom); orig[z] = src[z]; end
    model(16, 1'b0);
    push_exp(16);
    run(2, 16, 1'b0, 1'b1, 1'b1);
    for (int z = 0; z < 16; z++) begin src[z] = expv[z]; expv[z] = orig[z]; end
    push_exp(16);
    run(2, 16, 1'b1, 1'b1, 1'b1);
    stall_en = 1'b0;

    // Reset during WRITEBACK of step 5 on LANE_W=8, then a clean all-ones pass.
    for (int z = 0; z < 8; z++) src[z] = '1;
    do_start(1, 1'b0);
    load(1, 8, 1'b0, 1'b0);
    repeat (91) tick();
    check_eq("busy_before_reset", 64'(busy[1]), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("midop_reset",
             {32'd0, in_ready[1], out_valid[1], busy[1], done[1], 3'd0, out_slice[1]}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    for (int z = 0; z < 8; z++) expv[z] = '1;
    push_exp(8);
    run(1, 8, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
